// File: rtl/regfile_pkg.sv
// Shared register-file constants and address type for the LEGv8 core.
package regfile_pkg;

   localparam int NUM_REGS   = 32;
   localparam int REG_ADDR_W = 5;
   localparam int XZR        = 31;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage : regfile_pkg

// File: rtl/sb_counter.sv
// Per-register pending-write counter: saturating up/down with synchronous clear.
module sb_counter #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_clear,
   input  logic             i_inc,
   input  logic             i_dec,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_nonzero
);

   logic [CNT_W-1:0] r_cnt;
   logic             w_up;
   logic             w_dn;

   assign w_up      = i_inc & ~(&r_cnt);
   assign w_dn      = i_dec & (r_cnt != '0);
   assign o_cnt     = r_cnt;
   assign o_nonzero = (r_cnt != '0);

   // NOTE: reset is sampled on the clock edge (synchronous), and all state
   // updates use non-blocking assignments so every counter sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset_n || i_clear) begin
         r_cnt <= '0;
      end else if (w_up && !w_dn) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end else if (w_dn && !w_up) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

endmodule : sb_counter

// File: rtl/regfile_scoreboard.sv
// Write-tracking scoreboard: counts in-flight writes per register and stalls
// issue on any source with a pending write or a destination whose count is full.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int CNT_W    = 2,
   parameter int ZERO_REG = XZR
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  issue_valid,
   input  logic [REG_ADDR_W-1:0] issue_rs1,
   input  logic [REG_ADDR_W-1:0] issue_rs2,
   input  logic [REG_ADDR_W-1:0] issue_rd,
   input  logic                  issue_wr,
   output logic                  issue_stall,
   output logic                  issue_fire,
   input  logic                  wb_valid,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic                  flush,
   output logic [NUM_REGS-1:0]   busy,
   output logic [CNT_W+4:0]      outstanding,
   output logic                  wb_err
);

   localparam reg_addr_t ZERO_ADDR = reg_addr_t'(ZERO_REG);
   localparam int        OUT_W     = CNT_W + 5;

   logic [CNT_W-1:0]    w_cnt [NUM_REGS];
   logic [NUM_REGS-1:0] w_nonzero;
   logic [NUM_REGS-1:0] w_inc;
   logic [NUM_REGS-1:0] w_dec;
   logic                w_src1_hit;
   logic                w_src2_hit;
   logic                w_dst_full;
   logic                w_inc_any;
   logic                w_dec_any;
   logic                w_wb_orphan;
   logic [OUT_W-1:0]    r_outstanding;
   logic                r_wb_err;

   // No same-cycle bypass: a retiring source still stalls in its writeback cycle.
   assign w_src1_hit  = w_nonzero[issue_rs1] & (issue_rs1 != ZERO_ADDR);
   assign w_src2_hit  = w_nonzero[issue_rs2] & (issue_rs2 != ZERO_ADDR);
   assign w_dst_full  = issue_wr & (issue_rd != ZERO_ADDR) & (&w_cnt[issue_rd]);

   assign issue_stall = issue_valid & (w_src1_hit | w_src2_hit | w_dst_full);
   assign issue_fire  = issue_valid & ~issue_stall;

   assign w_inc_any   = issue_fire & issue_wr & (issue_rd != ZERO_ADDR);
   assign w_dec_any   = wb_valid & (wb_rd != ZERO_ADDR) & (w_cnt[wb_rd] != '0);
   assign w_wb_orphan = wb_valid & (wb_rd != ZERO_ADDR) & (w_cnt[wb_rd] == '0);

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
      assign w_inc[g] = w_inc_any & (issue_rd == reg_addr_t'(g));
      assign w_dec[g] = w_dec_any & (wb_rd == reg_addr_t'(g));

      sb_counter #(
         .CNT_W (CNT_W)
      ) u_cnt (
         .clk       (clk),
         .reset_n   (reset_n),
         .i_clear   (flush),
         .i_inc     (w_inc[g]),
         .i_dec     (w_dec[g]),
         .o_cnt     (w_cnt[g]),
         .o_nonzero (w_nonzero[g])
      );
   end

   // Running total follows the same +1/-1/0 rule as the per-register counters.
   always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
         r_outstanding <= '0;
      end else if (w_inc_any && !w_dec_any) begin
         r_outstanding <= r_outstanding + OUT_W'(1);
      end else if (w_dec_any && !w_inc_any) begin
         r_outstanding <= r_outstanding - OUT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_wb_err <= 1'b0;
      end else if (w_wb_orphan && !flush) begin
         r_wb_err <= 1'b1;
      end
   end

   assign busy        = w_nonzero;
   assign outstanding = r_outstanding;
   assign wb_err      = r_wb_err;

endmodule : regfile_scoreboard
